// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I instruction-fetch front end.
// Issues sequential fetches and queues {pc, instr} for IF/ID.
//
// Ports:
//   clk_i, synclr_ni          clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o   fetch request, word-aligned address
//   imem_gnt_i                request accepted this cycle
//   imem_rvalid_i, rdata_i    in-order instruction response
//   stall_i                   IF/ID holds; head is not popped
//   redirect_i, redirect_pc_i taken branch/jump from EX
//   if_valid_o, if_pc_o,
//   if_pc4_o, if_instr_o      head of the instruction queue
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        synclr_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o,
    output logic [31:0] if_instr_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DMAX = 3'(DEPTH);
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

    logic [31:0]   req_pc;
    logic [2:0]    outst;
    logic [2:0]    count;
    logic [2:0]    disc;

    logic [31:0]   pq_addr [DEPTH];
    logic [PW-1:0] pq_wp;
    logic [PW-1:0] pq_rp;

    logic [31:0]   iq_pc    [DEPTH];
    logic [31:0]   iq_instr [DEPTH];
    logic [PW-1:0] iq_wp;
    logic [PW-1:0] iq_rp;

    logic          head_v;
    logic          pop;
    logic          grant;
    logic          rv_ok;
    logic          push;
    logic [3:0]    credit;

    function automatic logic [PW-1:0] nxt(
        input logic [PW-1:0] p
    );
        return (p == PLAST) ? '0 : p + 1'b1;
    endfunction

    assign head_v     = (count != 3'd0);
    assign if_valid_o = head_v && !redirect_i;
    assign pop        = if_valid_o && !stall_i;

    // Slots in flight (including ones to be discarded)
    // plus queued entries, net of this cycle's pop.
    assign credit = {1'b0, outst}
                  + {1'b0, count}
                  - {3'b000, pop};

    assign imem_req_o = synclr_ni
                     && !redirect_i
                     && (credit < {1'b0, DMAX});
    assign imem_addr_o = req_pc;
    assign grant       = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is ignored.
    assign rv_ok = imem_rvalid_i && (outst != 3'd0);
    assign push  = rv_ok && (disc == 3'd0) && !redirect_i;

    assign if_pc_o    = if_valid_o ? iq_pc[iq_rp] : 32'h0;
    assign if_pc4_o   = if_pc_o + 32'd4;
    assign if_instr_o = if_valid_o ? iq_instr[iq_rp] : NOP;

    always_ff @(posedge clk_i or negedge synclr_ni) begin
        if (!synclr_ni) begin
            req_pc <= RESET_PC;
            outst  <= 3'd0;
            disc   <= 3'd0;
            count  <= 3'd0;
            pq_wp  <= '0;
            pq_rp  <= '0;
            iq_wp  <= '0;
            iq_rp  <= '0;
        end else if (redirect_i) begin
            // Everything still in flight becomes stale.
            req_pc <= redirect_pc_i;
            outst  <= outst - {2'b00, rv_ok};
            disc   <= outst - {2'b00, rv_ok};
            count  <= 3'd0;
            pq_wp  <= '0;
            pq_rp  <= '0;
            iq_wp  <= '0;
            iq_rp  <= '0;
        end else begin
            if (grant) begin
                req_pc <= req_pc + 32'd4;
                pq_wp  <= nxt(pq_wp);
            end
            outst <= outst
                   + {2'b00, grant}
                   - {2'b00, rv_ok};
            if (rv_ok && (disc != 3'd0)) begin
                disc <= disc - 3'd1;
            end
            if (push) begin
                pq_rp <= nxt(pq_rp);
                iq_wp <= nxt(iq_wp);
            end
            if (pop) begin
                iq_rp <= nxt(iq_rp);
            end
            count <= count
                   + {2'b00, push}
                   - {2'b00, pop};
        end
    end

    // Payload storage; validity is tracked by the
    // counters and pointers above.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            pq_addr[pq_wp] <= req_pc;
        end
        if (push) begin
            iq_pc[iq_wp]    <= pq_addr[pq_rp];
            iq_instr[iq_wp] <= imem_rdata_i;
        end
    end

endmodule
